// File: rtl/bbox_pixel_traverser.sv
// Rasterizer traversal: walks a clamped bbox row-major, one candidate pixel per cycle,
// stepping three edge functions incrementally. Option macro: TRAVERSER_EMIT_ALL_EN.
module bbox_pixel_traverser #(
    parameter int COORD_WIDTH = 10,
    parameter int EDGE_WIDTH  = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          ready,
    input  logic                          bb_valid,
    input  logic signed [COORD_WIDTH-1:0] min_x,
    input  logic signed [COORD_WIDTH-1:0] max_x,
    input  logic signed [COORD_WIDTH-1:0] min_y,
    input  logic signed [COORD_WIDTH-1:0] max_y,
    input  logic signed [EDGE_WIDTH-1:0]  e_init [3],
    input  logic signed [EDGE_WIDTH-1:0]  e_dx   [3],
    input  logic signed [EDGE_WIDTH-1:0]  e_dy   [3],
    output logic                          frag_valid,
    input  logic                          frag_ready,
    output logic signed [COORD_WIDTH-1:0] frag_x,
    output logic signed [COORD_WIDTH-1:0] frag_y,
    output logic signed [EDGE_WIDTH-1:0]  frag_e [3],
    output logic                          frag_inside,
    output logic                          done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]                   state;
    logic signed [COORD_WIDTH-1:0] cur_x, cur_y, start_x, lim_x, lim_y;
    logic signed [EDGE_WIDTH-1:0]  e_cur [3];
    logic signed [EDGE_WIDTH-1:0]  row_e [3];
    logic signed [EDGE_WIDTH-1:0]  step_x [3];
    logic signed [EDGE_WIDTH-1:0]  step_y [3];

    logic [COORD_WIDTH:0] x_next, y_next, lim_x_ext, lim_y_ext;
    logic                 last_x, last_y, slot_free, cand_inside, emit;

    // End tests use one extra bit so a limit of 2^(CW-1)-1 cannot wrap.
    assign x_next    = {cur_x[COORD_WIDTH-1], cur_x} + {{COORD_WIDTH{1'b0}}, 1'b1};
    assign y_next    = {cur_y[COORD_WIDTH-1], cur_y} + {{COORD_WIDTH{1'b0}}, 1'b1};
    assign lim_x_ext = {lim_x[COORD_WIDTH-1], lim_x};
    assign lim_y_ext = {lim_y[COORD_WIDTH-1], lim_y};
    assign last_x    = (x_next == lim_x_ext);
    assign last_y    = (y_next == lim_y_ext);

    assign ready       = (state == S_IDLE);
    assign slot_free   = !frag_valid || frag_ready;
    assign cand_inside = !e_cur[0][EDGE_WIDTH-1] && !e_cur[1][EDGE_WIDTH-1]
                       && !e_cur[2][EDGE_WIDTH-1];

`ifdef TRAVERSER_EMIT_ALL_EN
    assign emit = 1'b1;
`else
    assign emit = cand_inside;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            frag_valid  <= 1'b0;
            done        <= 1'b0;
            frag_x      <= '0;
            frag_y      <= '0;
            frag_inside <= 1'b0;
            cur_x       <= '0;
            cur_y       <= '0;
            start_x     <= '0;
            lim_x       <= '0;
            lim_y       <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                frag_e[i] <= '0;
                e_cur[i]  <= '0;
                row_e[i]  <= '0;
                step_x[i] <= '0;
                step_y[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (frag_valid && frag_ready)
                frag_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (bb_valid) begin
                            state   <= S_SCAN;
                            cur_x   <= min_x;
                            cur_y   <= min_y;
                            start_x <= min_x;
                            lim_x   <= max_x;
                            lim_y   <= max_y;
                            for (int unsigned i = 0; i < 3; i++) begin
                                e_cur[i]  <= e_init[i];
                                row_e[i]  <= e_init[i];
                                step_x[i] <= e_dx[i];
                                step_y[i] <= e_dy[i];
                            end
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end

                S_SCAN: begin
                    if (slot_free) begin
                        if (emit) begin
                            frag_valid  <= 1'b1;
                            frag_x      <= cur_x;
                            frag_y      <= cur_y;
                            frag_inside <= cand_inside;
                            for (int unsigned i = 0; i < 3; i++)
                                frag_e[i] <= e_cur[i];
                        end
                        if (last_x) begin
                            if (last_y) begin
                                state <= S_DRAIN;
                            end else begin
                                cur_x <= start_x;
                                cur_y <= cur_y + 1'b1;
                                for (int unsigned i = 0; i < 3; i++) begin
                                    row_e[i] <= row_e[i] + step_y[i];
                                    e_cur[i] <= row_e[i] + step_y[i];
                                end
                            end
                        end else begin
                            cur_x <= cur_x + 1'b1;
                            for (int unsigned i = 0; i < 3; i++)
                                e_cur[i] <= e_cur[i] + step_x[i];
                        end
                    end
                end

                S_DRAIN: begin
                    if (slot_free) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bbox_pixel_traverser.sv
// Table-driven bench for bbox_pixel_traverser: primitive/fragment tables with
// hand-computed expectations, plus directed reset, empty-bbox and back-to-back sequences.
module tb_bbox_pixel_traverser;

    localparam int CW = 10;
    localparam int EW = 24;

    logic                 clk = 1'b0;
    logic                 rst, start, bb_valid, frag_ready;
    logic signed [CW-1:0] min_x, max_x, min_y, max_y;
    logic signed [EW-1:0] e_init [3];
    logic signed [EW-1:0] e_dx   [3];
    logic signed [EW-1:0] e_dy   [3];
    logic                 ready, frag_valid, frag_inside, done;
    logic signed [CW-1:0] frag_x, frag_y;
    logic signed [EW-1:0] frag_e [3];

    bbox_pixel_traverser #(.COORD_WIDTH(CW), .EDGE_WIDTH(EW)) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready), .bb_valid(bb_valid),
        .min_x(min_x), .max_x(max_x), .min_y(min_y), .max_y(max_y),
        .e_init(e_init), .e_dx(e_dx), .e_dy(e_dy),
        .frag_valid(frag_valid), .frag_ready(frag_ready),
        .frag_x(frag_x), .frag_y(frag_y), .frag_e(frag_e),
        .frag_inside(frag_inside), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x, y, e0, e1, e2, ins;
    } frag_t;

    typedef struct {
        int mnx, mxx, mny, mxy;
        int ei0, ei1, ei2, dx0, dx1, dx2, dy0, dy1, dy2;
        int first, cnt, first_k, done_k;
    } prim_t;

    frag_t exp_q[$];
    prim_t prims[$];
    prim_t cur_p;
    int    total = 0;
    int    bad   = 0;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic check_frag(input string name, input frag_t f);
        total++;
        if (int'(frag_x) != f.x || int'(frag_y) != f.y || int'(frag_e[0]) != f.e0 ||
            int'(frag_e[1]) != f.e1 || int'(frag_e[2]) != f.e2 || int'(frag_inside) != f.ins) begin
            bad++;
            $display("FAIL %s: got (%0d,%0d e=%0d,%0d,%0d in=%0d) want (%0d,%0d e=%0d,%0d,%0d in=%0d)",
                     name, frag_x, frag_y, frag_e[0], frag_e[1], frag_e[2], frag_inside,
                     f.x, f.y, f.e0, f.e1, f.e2, f.ins);
        end
    endtask

    task automatic begin_prim(input int mnx, input int mxx, input int mny, input int mxy,
                              input int ei0, input int ei1, input int ei2,
                              input int dx0, input int dx1, input int dx2,
                              input int dy0, input int dy1, input int dy2,
                              input int first_k, input int done_k);
        cur_p.mnx = mnx; cur_p.mxx = mxx; cur_p.mny = mny; cur_p.mxy = mxy;
        cur_p.ei0 = ei0; cur_p.ei1 = ei1; cur_p.ei2 = ei2;
        cur_p.dx0 = dx0; cur_p.dx1 = dx1; cur_p.dx2 = dx2;
        cur_p.dy0 = dy0; cur_p.dy1 = dy1; cur_p.dy2 = dy2;
        cur_p.first   = exp_q.size();
        cur_p.first_k = first_k;
        cur_p.done_k  = done_k;
    endtask

    task automatic add_frag(input int x, input int y, input int e0, input int e1,
                            input int e2, input int ins);
        frag_t f;
        f.x = x; f.y = y; f.e0 = e0; f.e1 = e1; f.e2 = e2; f.ins = ins;
        exp_q.push_back(f);
    endtask

    task automatic end_prim();
        cur_p.cnt = exp_q.size() - cur_p.first;
        prims.push_back(cur_p);
    endtask

    task automatic drive_prim(input prim_t p);
        min_x = CW'(p.mnx); max_x = CW'(p.mxx);
        min_y = CW'(p.mny); max_y = CW'(p.mxy);
        e_init[0] = EW'(p.ei0); e_init[1] = EW'(p.ei1); e_init[2] = EW'(p.ei2);
        e_dx[0]   = EW'(p.dx0); e_dx[1]   = EW'(p.dx1); e_dx[2]   = EW'(p.dx2);
        e_dy[0]   = EW'(p.dy0); e_dy[1]   = EW'(p.dy1); e_dy[2]   = EW'(p.dy2);
        bb_valid  = 1'b1;
    endtask

    // mode 0: frag_ready always high; mode 1: frag_ready pattern 1,0,0 repeating
    task automatic run_prim(input int pi, input int mode);
        prim_t p;
        int    got, k, last_hs, first_k;
        bit    fin, prev_stall;
        int    sx, sy, se0, se1, se2, sins;
        p = prims[pi];
        got = 0; k = 0; last_hs = -1; first_k = -1; fin = 0; prev_stall = 0;
        sx = 0; sy = 0; se0 = 0; se1 = 0; se2 = 0; sins = 0;
        @(negedge clk);
        drive_prim(p);
        check("ready_idle", ready, 1);
        start = 1'b1;
        frag_ready = 1'b1;
        while (!fin && k < 200) begin
            k++;
            @(negedge clk);
            start = 1'b0;
            frag_ready = (mode == 0) ? 1'b1 : ((k % 3) == 1);
            if (k == 1) check("ready_busy", ready, 0);
            if (prev_stall) begin
                check("stall_hold", (frag_valid && int'(frag_x) == sx && int'(frag_y) == sy &&
                      int'(frag_e[0]) == se0 && int'(frag_e[1]) == se1 &&
                      int'(frag_e[2]) == se2 && int'(frag_inside) == sins), 1);
            end else if (frag_valid) begin
                if (first_k < 0) first_k = k;
                if (got < p.cnt) check_frag($sformatf("frag_p%0d_%0d", pi, got), exp_q[p.first + got]);
                else check("extra_frag", got + 1, p.cnt);
            end
            if (frag_valid && frag_ready) begin
                got++;
                last_hs = k;
            end
            prev_stall = frag_valid && !frag_ready;
            sx = int'(frag_x); sy = int'(frag_y); se0 = int'(frag_e[0]);
            se1 = int'(frag_e[1]); se2 = int'(frag_e[2]); sins = int'(frag_inside);
            if (done) begin
                fin = 1;
                check("done_count", got, p.cnt);
                check("done_ready", ready, 1);
                if (p.cnt > 0) check("done_after_last_hs", k, last_hs + 1);
                if (mode == 0) begin
                    check("done_cycle", k, p.done_k);
                    check("first_frag_cycle", first_k, p.first_k);
                end
            end
        end
        check("done_seen", fin, 1);
        @(negedge clk);
        check("done_pulse_width", done, 0);
    endtask

    initial begin
        bit    seen_bad;
        int    hs, k;
        bit    fin;
        frag_t f00;

        // P0: 4x2 all-zero edges, every pixel inside
        begin_prim(0, 4, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 10);
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++)
                add_frag(x, y, 0, 0, 0, 1);
        end_prim();
`ifdef TRAVERSER_EMIT_ALL_EN
        begin_prim(0, 3, 0, 1, -1, 0, 0, 1, 0, 0, 0, 0, 0, 2, 5);
        add_frag(0, 0, -1, 0, 0, 0);
        add_frag(1, 0, 0, 0, 0, 1);
        add_frag(2, 0, 1, 0, 0, 1);
        end_prim();
        begin_prim(2, 4, 5, 7, 3, -1, 5, -2, 1, 0, 0, 0, -4, 2, 6);
        add_frag(2, 5, 3, -1, 5, 0);
        add_frag(3, 5, 1, 0, 5, 1);
        add_frag(2, 6, 3, -1, 1, 0);
        add_frag(3, 6, 1, 0, 1, 1);
        end_prim();
`else
        begin_prim(0, 3, 0, 1, -1, 0, 0, 1, 0, 0, 0, 0, 0, 3, 5);
        add_frag(1, 0, 0, 0, 0, 1);
        add_frag(2, 0, 1, 0, 0, 1);
        end_prim();
        begin_prim(2, 4, 5, 7, 3, -1, 5, -2, 1, 0, 0, 0, -4, 3, 6);
        add_frag(3, 5, 1, 0, 5, 1);
        add_frag(3, 6, 1, 0, 1, 1);
        end_prim();
`endif
        // P3: limits at the positive coordinate extreme
        begin_prim(509, 511, 510, 511, 0, 0, 0, 1, 2, 3, 0, 0, 0, 2, 4);
        add_frag(509, 510, 0, 0, 0, 1);
        add_frag(510, 510, 1, 2, 3, 1);
        end_prim();
        // P4: negative coordinates, max_x = 0
        begin_prim(-2, 0, -1, 0, 10, 10, 10, -6, 0, 0, 0, 0, 0, 2, 4);
        add_frag(-2, -1, 10, 10, 10, 1);
        add_frag(-1, -1, 4, 10, 10, 1);
        end_prim();

        rst = 1'b1; start = 1'b0; bb_valid = 1'b0; frag_ready = 1'b0;
        drive_prim(prims[0]);
        bb_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_frag_valid", frag_valid, 0);
        check("rst_done", done, 0);
        check("rst_frag_x", frag_x, 0);
        check("rst_frag_y", frag_y, 0);
        check("rst_frag_e0", frag_e[0], 0);
        check("rst_frag_e2", frag_e[2], 0);
        check("rst_inside", frag_inside, 0);
        rst = 1'b0;

        for (int i = 0; i < prims.size(); i++)
            run_prim(i, 0);

        // empty bbox: immediate done, no fragments
        @(negedge clk);
        bb_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("empty_done", done, 1);
        check("empty_ready", ready, 1);
        check("empty_no_frag", frag_valid, 0);
        @(negedge clk);
        check("empty_done_clear", done, 0);
        check("empty_no_frag2", frag_valid, 0);

        run_prim(0, 1);
        run_prim(2, 1);

        // reset after the 3rd accepted fragment
        @(negedge clk);
        drive_prim(prims[0]);
        start = 1'b1;
        frag_ready = 1'b1;
        hs = 0; k = 0;
        while (hs < 3 && k < 50) begin
            k++;
            @(negedge clk);
            start = 1'b0;
            if (frag_valid && frag_ready) hs++;
        end
        check("rst_seq_three_frags", hs, 3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_frag_valid", frag_valid, 0);
        check("midrst_ready", ready, 1);
        check("midrst_done", done, 0);
        seen_bad = 0;
        repeat (15) begin
            @(negedge clk);
            if (done || frag_valid) seen_bad = 1;
        end
        check("midrst_quiet", seen_bad, 0);

        // start held across done: second primitive accepted in the done cycle
        @(negedge clk);
        drive_prim(prims[0]);
        start = 1'b1;
        frag_ready = 1'b1;
        fin = 0; k = 0;
        while (!fin && k < 50) begin
            k++;
            @(negedge clk);
            if (done) fin = 1;
        end
        check("b2b_first_done", fin, 1);
        @(negedge clk);
        start = 1'b0;
        check("b2b_accepted", ready, 0);
        check("b2b_no_frag_yet", frag_valid, 0);
        @(negedge clk);
        check("b2b_frag_valid", frag_valid, 1);
        f00.x = 0; f00.y = 0; f00.e0 = 0; f00.e1 = 0; f00.e2 = 0; f00.ins = 1;
        check_frag("b2b_first_frag", f00);
        fin = 0; k = 0;
        while (!fin && k < 50) begin
            k++;
            @(negedge clk);
            if (done) fin = 1;
        end
        check("b2b_second_done", fin, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
